risc16ba_mem_arbiter: RTL and testbench
=======================================

# risc16ba_mem_arbiter

Shares one single-port, 16-bit-wide, byte-writable synchronous SRAM between three requesters:
- the risc16ba instruction-fetch port (I);
- the risc16ba data port (D);
- a host/loader port (H), used for image loading and result dump.

It replaces the dual-port combinational memory model. The CPU sees variable latency through per-port ack handshakes and stalls until ack.

## Interface
Parameters:
- STARVE_LIMIT, default 8: number of lost arbitrations after which a waiting H request wins over D and I. Legal range is 1–255.

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  16  fetch byte address; bit 0 ignored
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  16  fetched word {mem[a&~1], mem[a|1]}
- d_req  in  1  data request; held until d_ack
- d_addr  in  16  data byte address; bit 0 ignored
- d_we  in  1  1 = write, 0 = read
- d_be  in  2  byte enables; [1] = high byte (even address), [0] = low byte (odd address)
- d_wdata  in  16  write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  16  read data, valid with d_ack
- h_req, h_addr, h_we, h_be, h_wdata, h_ack, h_rdata: same widths and meaning as the D port
- maddr  out  16  SRAM address, bit 0 forced 0
- moe  out  1  SRAM read strobe
- mwe0  out  1  SRAM high-byte write enable
- mwe1  out  1  SRAM low-byte write enable
- mwdata  out  16  SRAM write data
- mrdata  in  16  SRAM read data; registered inside the SRAM, valid the cycle after moe

## Operation
- The FSM has three states: IDLE, ACCESS and ACK.
- Arbitration is evaluated in IDLE, and in ACK with the requester currently being acked excluded.
  - Priority is D > I > H, except that H wins outright when h_wait == STARVE_LIMIT.
  - If there is a winner, the next state is ACCESS. Otherwise the next state is IDLE.
- Grant latch: on entering ACCESS, the winner's id, addr, we, be and wdata are registered.
  - maddr, moe, mwe0, mwe1 and mwdata are driven from these registers during ACCESS only.
  - They are zero in every other state.
- Strobe encoding:
  - moe = !we.
  - mwe0 = we & be[1].
  - mwe1 = we & be[0].
  - A write with be == 2'b00 still runs a full ACCESS/ACK cycle with no byte written.
- ACCESS always goes to ACK. In ACK, exactly the granted port's ack is 1.
- Read data: x_rdata = mrdata combinationally for all ports. It is meaningful only while x_ack = 1. Write acks also occur, and their rdata is don't-care.
- h_wait counter, width $clog2(STARVE_LIMIT+1):
  - increments, saturating at STARVE_LIMIT, at each arbitration where h_req = 1 and H loses;
  - clears when H is granted, or when h_req = 0.
- The ack-cycle exclusion means a requester that keeps req high through its ack cycle is treated as issuing a new request from the following cycle.
- Reset values: state = IDLE, h_wait = 0. All acks, moe, mwe0 and mwe1 are 0. maddr and mwdata are 0.

## Timing
- Request first seen high in cycle T with the arbiter in IDLE and winning:
  - SRAM strobes are active in T+1;
  - ack and rdata are valid in T+2.
- Back-to-back grants sustain one access every 2 cycles (ACK → ACCESS → ACK …).
- Inputs are sampled only at arbitration. After that, the latched copy is used.
- Requesters must still hold req, addr, we, be and wdata stable until ack. Behaviour on an early drop is undefined.
- Simultaneous requests from D, I and H in IDLE: D is served first, then I, then H. H is at T+6 if nothing else arrives.
- rst asserted during ACCESS:
  - the strobes driven in that cycle are sampled by the SRAM at that edge, so the write completes;
  - the ack is suppressed;
  - all outputs take their reset values after that edge.
- rst asserted during ACK: the ack in that cycle is still visible, and state → IDLE.

## Configuration
- MEM_ARB_HOST_EN defined: the H port and the h_wait starvation logic are compiled in.
- MEM_ARB_HOST_EN undefined:
  - the H ports remain in the port list, so the interface is stable;
  - h_req, h_addr, h_we, h_be and h_wdata are ignored;
  - h_ack is tied to 0 and h_rdata to 16'h0000;
  - h_wait logic is absent, and arbitration is D > I only.

## Test plan
- Reset:
  - Stimulus: rst = 1 for 2 cycles with all req = 1.
  - Response: all acks and strobes stay 0; the first ack (d_ack) appears 2 cycles after rst falls.
- Single read:
  - Stimulus: i_req with i_addr = 16'h0031, where mem[0x30] = 8'hAB and mem[0x31] = 8'hCD.
  - Response: maddr = 16'h0030 and moe = 1 at T+1; i_ack = 1 with i_rdata = 16'hABCD at T+2.
- Byte write:
  - Stimulus: d_we = 1, d_be = 2'b01, d_addr = 16'h0200, d_wdata = 16'h1234.
  - Response: mwe1 = 1 and mwe0 = 0 at T+1; mem[0x201] = 8'h34; mem[0x200] is unchanged.
- Contention:
  - Stimulus: i_req and d_req both high from T.
  - Response: d_ack at T+2, i_ack at T+4, with no idle cycle between the two accesses.
- Starvation (STARVE_LIMIT = 2, MEM_ARB_HOST_EN defined):
  - Stimulus: D and I requesting continuously while h_req is held high.
  - Response: H is granted at the third arbitration after h_req rose, ahead of pending D; h_wait returns to 0.
- Host port disabled (MEM_ARB_HOST_EN undefined):
  - Stimulus: h_req = 1 held for 20 cycles.
  - Response: h_ack is never 1 and the memory strobes stay 0.

Source files
------------

// File: rtl/risc16ba_mem_arbiter.sv
// Three-way arbiter (data, fetch, host) sharing one byte-writable synchronous SRAM.
// Define MEM_ARB_HOST_EN to compile in the host port and its starvation counter.
module risc16ba_mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_be,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    input  logic        h_req,
    input  logic [15:0] h_addr,
    input  logic        h_we,
    input  logic [1:0]  h_be,
    input  logic [15:0] h_wdata,
    output logic        h_ack,
    output logic [15:0] h_rdata,
    output logic [15:0] maddr,
    output logic        moe,
    output logic        mwe0,
    output logic        mwe1,
    output logic [15:0] mwdata,
    input  logic [15:0] mrdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;
    typedef enum logic [1:0] {PORT_NONE, PORT_D, PORT_I, PORT_H} port_e;

    state_e        state_q, state_d;
    port_e         gnt_q, gnt_d;
    logic [15:1]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          arb_en;
    logic          d_elig, i_elig, h_elig, h_starved;
    port_e         winner;

    assign arb_en = (state_q == IDLE) || (state_q == ACK);

    // The port being acked this cycle cannot win again until the next cycle.
    assign d_elig = d_req && !(state_q == ACK && gnt_q == PORT_D);
    assign i_elig = i_req && !(state_q == ACK && gnt_q == PORT_I);

`ifdef MEM_ARB_HOST_EN
    localparam int HW = $clog2(STARVE_LIMIT + 1);
    localparam logic [HW-1:0] LIMIT = HW'(STARVE_LIMIT);

    logic [HW-1:0] h_wait_q, h_wait_d;

    assign h_elig    = h_req && !(state_q == ACK && gnt_q == PORT_H);
    assign h_starved = (h_wait_q == LIMIT);

    always_comb begin
        h_wait_d = h_wait_q;
        if (!h_req) begin
            h_wait_d = '0;
        end else if (arb_en) begin
            if (winner == PORT_H) begin
                h_wait_d = '0;
            end else if (h_elig && h_wait_q != LIMIT) begin
                h_wait_d = h_wait_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_wait_q <= '0;
        end else begin
            h_wait_q <= h_wait_d;
        end
    end

    assign h_ack   = (state_q == ACK) && (gnt_q == PORT_H);
    assign h_rdata = mrdata;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{i_addr[0], d_addr[0], h_addr[0]};
`else
    assign h_elig    = 1'b0;
    assign h_starved = 1'b0;
    assign h_ack     = 1'b0;
    assign h_rdata   = 16'h0000;

    logic unused_host;
    assign unused_host = ^{i_addr[0], d_addr[0], h_req, h_addr, h_we, h_be, h_wdata,
                           8'(STARVE_LIMIT)};
`endif

    always_comb begin
        winner = PORT_NONE;
        if (h_elig && h_starved) begin
            winner = PORT_H;
        end else if (d_elig) begin
            winner = PORT_D;
        end else if (i_elig) begin
            winner = PORT_I;
        end else if (h_elig) begin
            winner = PORT_H;
        end
    end

    // Grant latch: requester inputs are only looked at here, then held internally.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, ACK: begin
                state_d = IDLE;
                if (winner != PORT_NONE) begin
                    state_d = ACCESS;
                    gnt_d   = winner;
                end
                if (winner == PORT_D) begin
                    addr_d  = d_addr[15:1];
                    we_d    = d_we;
                    be_d    = d_be;
                    wdata_d = d_wdata;
                end else if (winner == PORT_I) begin
                    addr_d  = i_addr[15:1];
                    we_d    = 1'b0;
                    be_d    = 2'b11;
                    wdata_d = 16'h0000;
                end else if (winner == PORT_H) begin
                    addr_d  = h_addr[15:1];
                    we_d    = h_we;
                    be_d    = h_be;
                    wdata_d = h_wdata;
                end
            end
            ACCESS:  state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= PORT_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        maddr  = 16'h0000;
        moe    = 1'b0;
        mwe0   = 1'b0;
        mwe1   = 1'b0;
        mwdata = 16'h0000;
        if (state_q == ACCESS) begin
            maddr  = {addr_q, 1'b0};
            moe    = !we_q;
            mwe0   = we_q & be_q[1];
            mwe1   = we_q & be_q[0];
            mwdata = wdata_q;
        end
    end

    assign d_ack   = (state_q == ACK) && (gnt_q == PORT_D);
    assign i_ack   = (state_q == ACK) && (gnt_q == PORT_I);
    assign d_rdata = mrdata;
    assign i_rdata = mrdata;

endmodule

// File: tb/tb_risc16ba_mem_arbiter.sv
// Directed bench for risc16ba_mem_arbiter with a byte-addressed synchronous SRAM model.
// Covers the host-port starvation path when MEM_ARB_HOST_EN is defined.
module tb_risc16ba_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_we;
    logic [1:0]  d_be;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        h_req;
    logic [15:0] h_addr;
    logic        h_we;
    logic [1:0]  h_be;
    logic [15:0] h_wdata;
    logic        h_ack;
    logic [15:0] h_rdata;
    logic [15:0] maddr;
    logic        moe;
    logic        mwe0;
    logic        mwe1;
    logic [15:0] mwdata;
    logic [15:0] mrdata;

    logic [7:0]  mem [0:65535];
    logic        loadEn;
    logic [15:0] loadAddr;
    logic [7:0]  loadData;

    int checkCount;
    int failCount;

    risc16ba_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .h_req(h_req), .h_addr(h_addr), .h_we(h_we), .h_be(h_be), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .maddr(maddr), .moe(moe), .mwe0(mwe0), .mwe1(mwe1), .mwdata(mwdata),
        .mrdata(mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: byte writes and a registered read port, plus a preload path.
    always @(posedge clk) begin
        if (loadEn) mem[loadAddr] <= loadData;
        if (mwe0) mem[maddr] <= mwdata[15:8];
        if (mwe1) mem[maddr | 16'h0001] <= mwdata[7:0];
        if (moe) mrdata <= {mem[maddr], mem[maddr | 16'h0001]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Control vector order: {moe, mwe0, mwe1, d_ack, i_ack, h_ack}.
    task automatic checkCtl(input string tag, input logic [5:0] expected);
        checkOutput(tag, {10'b0, moe, mwe0, mwe1, d_ack, i_ack, h_ack}, {10'b0, expected});
    endtask

    task automatic applyStimulus(input logic req, input logic [15:0] addr, input logic we,
                                 input logic [1:0] be, input logic [15:0] wdata);
        d_req   = req;
        d_addr  = addr;
        d_we    = we;
        d_be    = be;
        d_wdata = wdata;
    endtask

    task automatic loadByte(input logic [15:0] addr, input logic [7:0] data);
        loadEn   = 1'b1;
        loadAddr = addr;
        loadData = data;
        tick();
        loadEn   = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        loadEn = 1'b0; loadAddr = '0; loadData = '0;
        i_req = 1'b0; i_addr = '0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        h_req = 1'b0; h_addr = '0; h_we = 1'b0; h_be = 2'b00; h_wdata = '0;
        tick();
        loadByte(16'h0030, 8'hAB);
        loadByte(16'h0031, 8'hCD);
        loadByte(16'h0200, 8'h55);
        loadByte(16'h0201, 8'h66);
        loadByte(16'h0202, 8'h11);
        loadByte(16'h0203, 8'h77);

        $display("[TB] reset with all requests high");
        applyStimulus(1'b1, 16'h0030, 1'b0, 2'b11, 16'h0000);
        i_req = 1'b1; i_addr = 16'h0031;
        h_req = 1'b1; h_addr = 16'h0030;
        tick();
        checkCtl("rst cycle1 ctl", 6'b000000);
        checkOutput("rst cycle1 maddr", maddr, 16'h0000);
        tick();
        checkCtl("rst cycle2 ctl", 6'b000000);
        checkOutput("rst cycle2 mwdata", mwdata, 16'h0000);
        rst = 1'b0;
        h_req = 1'b0;
        checkCtl("rst release ctl", 6'b000000);
        tick();
        checkCtl("rst T+1 ctl", 6'b100000);
        checkOutput("rst T+1 maddr", maddr, 16'h0030);
        tick();
        checkCtl("rst T+2 d_ack", 6'b000100);
        checkOutput("rst T+2 d_rdata", d_rdata, 16'hABCD);
        d_req = 1'b0;
        tick();
        checkCtl("rst T+3 ctl", 6'b100000);
        tick();
        checkCtl("rst T+4 i_ack", 6'b000010);
        checkOutput("rst T+4 i_rdata", i_rdata, 16'hABCD);
        i_req = 1'b0;
        tick();
        checkCtl("rst idle", 6'b000000);

        $display("[TB] single fetch");
        i_req = 1'b1; i_addr = 16'h0031;
        checkCtl("read T ctl", 6'b000000);
        tick();
        checkCtl("read T+1 ctl", 6'b100000);
        checkOutput("read T+1 maddr", maddr, 16'h0030);
        tick();
        checkCtl("read T+2 ctl", 6'b000010);
        checkOutput("read T+2 i_rdata", i_rdata, 16'hABCD);
        i_req = 1'b0;
        tick();
        checkCtl("read idle", 6'b000000);

        $display("[TB] byte writes");
        applyStimulus(1'b1, 16'h0200, 1'b1, 2'b01, 16'h1234);
        tick();
        checkCtl("wr lo T+1 ctl", 6'b001000);
        checkOutput("wr lo maddr", maddr, 16'h0200);
        checkOutput("wr lo mwdata", mwdata, 16'h1234);
        tick();
        checkCtl("wr lo T+2 ctl", 6'b000100);
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        checkOutput("wr lo mem201", {8'h00, mem[16'h0201]}, 16'h0034);
        checkOutput("wr lo mem200", {8'h00, mem[16'h0200]}, 16'h0055);
        tick();

        applyStimulus(1'b1, 16'h0203, 1'b1, 2'b10, 16'hBEEF);
        tick();
        checkCtl("wr hi T+1 ctl", 6'b010000);
        checkOutput("wr hi maddr", maddr, 16'h0202);
        tick();
        checkCtl("wr hi T+2 ctl", 6'b000100);
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        checkOutput("wr hi mem202", {8'h00, mem[16'h0202]}, 16'h00BE);
        checkOutput("wr hi mem203", {8'h00, mem[16'h0203]}, 16'h0077);
        tick();

        applyStimulus(1'b1, 16'h0200, 1'b1, 2'b00, 16'hFFFF);
        tick();
        checkCtl("wr none T+1 ctl", 6'b000000);
        checkOutput("wr none maddr", maddr, 16'h0200);
        tick();
        checkCtl("wr none T+2 ctl", 6'b000100);
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        checkOutput("wr none mem", {mem[16'h0200], mem[16'h0201]}, 16'h5534);
        tick();

        $display("[TB] contention D vs I");
        applyStimulus(1'b1, 16'h0200, 1'b0, 2'b11, 16'h0000);
        i_req = 1'b1; i_addr = 16'h0030;
        tick();
        checkCtl("cont T+1 ctl", 6'b100000);
        checkOutput("cont T+1 maddr", maddr, 16'h0200);
        tick();
        checkCtl("cont T+2 ctl", 6'b000100);
        checkOutput("cont T+2 d_rdata", d_rdata, 16'h5534);
        d_req = 1'b0;
        tick();
        checkCtl("cont T+3 ctl", 6'b100000);
        checkOutput("cont T+3 maddr", maddr, 16'h0030);
        tick();
        checkCtl("cont T+4 ctl", 6'b000010);
        checkOutput("cont T+4 i_rdata", i_rdata, 16'hABCD);
        i_req = 1'b0;
        tick();

        $display("[TB] request held through ack");
        applyStimulus(1'b1, 16'h0202, 1'b0, 2'b11, 16'h0000);
        tick();
        checkCtl("hold T+1 ctl", 6'b100000);
        tick();
        checkCtl("hold T+2 ctl", 6'b000100);
        checkOutput("hold T+2 d_rdata", d_rdata, 16'hBE77);
        tick();
        checkCtl("hold T+3 ctl", 6'b000000);
        tick();
        checkCtl("hold T+4 ctl", 6'b100000);
        tick();
        checkCtl("hold T+5 ctl", 6'b000100);
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        tick();

        $display("[TB] reset during access and ack");
        applyStimulus(1'b1, 16'h0204, 1'b1, 2'b11, 16'hA5C3);
        tick();
        checkCtl("rstacc T+1 ctl", 6'b011000);
        rst = 1'b1;
        tick();
        checkCtl("rstacc after ctl", 6'b000000);
        checkOutput("rstacc mem", {mem[16'h0204], mem[16'h0205]}, 16'hA5C3);
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 16'h0030, 1'b0, 2'b11, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        checkCtl("rstack ack visible", 6'b000100);
        tick();
        checkCtl("rstack after ctl", 6'b000000);
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        tick();

`ifdef MEM_ARB_HOST_EN
        $display("[TB] host starvation");
        applyStimulus(1'b1, 16'h0200, 1'b0, 2'b11, 16'h0000);
        i_req = 1'b1; i_addr = 16'h0030;
        h_req = 1'b1; h_addr = 16'h0202; h_we = 1'b0; h_be = 2'b11;
        checkOutput("starve T hwait", 16'(dut.h_wait_q), 16'd0);
        tick();
        checkOutput("starve T+1 maddr", maddr, 16'h0200);
        checkOutput("starve T+1 hwait", 16'(dut.h_wait_q), 16'd1);
        tick();
        checkCtl("starve T+2 ctl", 6'b000100);
        tick();
        checkOutput("starve T+3 maddr", maddr, 16'h0030);
        checkOutput("starve T+3 hwait", 16'(dut.h_wait_q), 16'd2);
        tick();
        checkCtl("starve T+4 ctl", 6'b000010);
        tick();
        checkCtl("starve T+5 ctl", 6'b100000);
        checkOutput("starve T+5 maddr", maddr, 16'h0202);
        checkOutput("starve T+5 hwait", 16'(dut.h_wait_q), 16'd0);
        tick();
        checkCtl("starve T+6 ctl", 6'b000001);
        checkOutput("starve T+6 h_rdata", h_rdata, 16'hBE77);
        applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
        i_req = 1'b0;
        h_req = 1'b0;
        tick();
        checkCtl("starve idle", 6'b000000);
`else
        $display("[TB] host port disabled");
        h_req = 1'b1; h_addr = 16'h0030; h_we = 1'b1; h_be = 2'b11; h_wdata = 16'hFFFF;
        for (int n = 0; n < 20; n++) begin
            tick();
            checkCtl("host off ctl", 6'b000000);
            checkOutput("host off h_rdata", h_rdata, 16'h0000);
        end
        h_req = 1'b0;
        checkOutput("host off mem", {mem[16'h0030], mem[16'h0031]}, 16'hABCD);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
